// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches instructions over a req/ack handshake,
// holds the executing instruction for the decoder and selects the next PC
// from the decoder's jump/exception outputs, the ALU zero flag and rs data.
// Interrupts and exceptions redirect to VECTOR_PC (supervisor, bit 31 set).
// Optional feature macro: IMEM_TIMEOUT_EN. When defined, a fetch that waits
// TIMEOUT_CYCLES cycles without ack pulses fetch_fault and restarts at
// VECTOR_PC. When undefined, a fetch waits forever and fetch_fault is 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] VECTOR_PC      = 32'h8000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc31,
  input  logic        irq_in,
  output logic        irq,
  input  logic [1:0]  jump,
  input  logic        exception,
  input  logic        zero,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic        fetch_fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  // Elaboration-time sanity check on the configuration.
  if (VECTOR_PC[31] != 1'b1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("fetch_unit: VECTOR_PC[31] must be 1 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_sync1, r_sync2, r_sync_d;
  logic        r_pend;
  logic        w_edge, w_retire, w_take_irq, w_timeout;
  logic [31:0] w_pc_plus4, w_next_pc, w_br_off;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_off    = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_retire    = (r_state == S_EXEC) && !stall;
  // Interrupts are masked (but kept pending) while in supervisor space.
  assign w_take_irq  = r_pend && !r_pc[31];
  assign w_edge      = r_sync2 && !r_sync_d;

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = (r_state == S_EXEC);
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign pc31        = r_pc[31];
  assign irq         = r_pend && instr_valid && !r_pc[31];

  // Next-PC select, highest priority first; all arithmetic wraps mod 2^32.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (w_take_irq)
      w_next_pc = VECTOR_PC;
    else if (exception)
      w_next_pc = VECTOR_PC;
    else if (jump == 2'b11)
      w_next_pc = rs_data;
    else if (jump == 2'b10)
      w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    else if (jump == 2'b01 && (zero ^ r_instr[26]))
      w_next_pc = w_pc_plus4 + w_br_off;
  end

  // Two-flop irq synchroniser, edge detector and pending latch. A new edge
  // in the same cycle the pending interrupt is taken re-arms it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_sync1  <= irq_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
      r_pend   <= w_edge || (r_pend && !(w_retire && w_take_irq));
    end
  end

`ifdef IMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] r_cnt;
  logic          r_fault;

  assign w_timeout   = (r_state == S_FETCH) && !imem_ack &&
                       (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign fetch_fault = r_fault;

  // Count unacknowledged FETCH cycles; fault pulse follows the expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_timeout;
      if (r_state != S_FETCH || imem_ack || w_timeout)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Main IDLE -> FETCH -> EXEC sequencer, PC and instruction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= S_EXEC;
          end else if (w_timeout) begin
            r_pc    <= VECTOR_PC;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            r_pc    <= w_next_pc;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
